// File: rtl/axi4_read_arbiter_pkg.sv
// axi4_read_arbiter_pkg: shared types and constants for the two-port AXI4 read arbiter.
package axi4_read_arbiter_pkg;
    typedef enum logic {IDLE, ISSUE} arb_state_t;
    typedef logic port_idx_t;
    // ID and address are parameter-sized, so they are held beside this struct in the top.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } ar_payload_t;
    localparam logic [3:0] AR_CACHE_DEFAULT = 4'b0011;
    localparam int CNT_WIDTH = 4;
endpackage

// File: rtl/axi4_read_arbiter_tracker.sv
// outstanding_tracker: per-port count of accepted-but-incomplete bursts with limit and sticky underflow flag.
module outstanding_tracker
    import axi4_read_arbiter_pkg::*;
#(
    parameter int C_MAX_OUTSTANDING = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_busy,
    output logic o_err
);
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_err;
    logic                 w_under;

    // A retire with nothing outstanding is dropped and flagged instead of wrapping.
    assign w_under = i_dec & (r_cnt == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(i_inc) - CNT_WIDTH'(i_dec & ~w_under);
            if (w_under) r_err <= 1'b1;
        end
    end

    assign o_full = r_cnt >= CNT_WIDTH'(C_MAX_OUTSTANDING);
    assign o_busy = r_cnt != '0;
    assign o_err  = r_err;
endmodule

// File: rtl/axi4_read_arbiter.sv
// axi4_read_arbiter: shares one AXI4 AR/R master between the CPU datapath (port 0) and HDMI scanout (port 1).
// One AR in flight at a time, ARID tagged with the port index, R beats routed back by RID MSB.
module axi4_read_arbiter
    import axi4_read_arbiter_pkg::*;
#(
    parameter int C_ID_WIDTH        = 2,
    parameter int C_ADDR_WIDTH      = 32,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_MAX_OUTSTANDING = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [C_ID_WIDTH-1:0]   S0_ARID,
    input  logic [C_ADDR_WIDTH-1:0] S0_ARADDR,
    input  logic [7:0]              S0_ARLEN,
    input  logic [2:0]              S0_ARSIZE,
    input  logic [1:0]              S0_ARBURST,
    input  logic                    S0_ARVALID,
    output logic                    S0_ARREADY,
    output logic [C_ID_WIDTH-1:0]   S0_RID,
    output logic [C_DATA_WIDTH-1:0] S0_RDATA,
    output logic [1:0]              S0_RRESP,
    output logic                    S0_RLAST,
    output logic                    S0_RVALID,
    input  logic                    S0_RREADY,
    input  logic [C_ID_WIDTH-1:0]   S1_ARID,
    input  logic [C_ADDR_WIDTH-1:0] S1_ARADDR,
    input  logic [7:0]              S1_ARLEN,
    input  logic [2:0]              S1_ARSIZE,
    input  logic [1:0]              S1_ARBURST,
    input  logic                    S1_ARVALID,
    output logic                    S1_ARREADY,
    output logic [C_ID_WIDTH-1:0]   S1_RID,
    output logic [C_DATA_WIDTH-1:0] S1_RDATA,
    output logic [1:0]              S1_RRESP,
    output logic                    S1_RLAST,
    output logic                    S1_RVALID,
    input  logic                    S1_RREADY,
    input  logic                    S1_URGENT,
    output logic [C_ID_WIDTH:0]     M_ARID,
    output logic [C_ADDR_WIDTH-1:0] M_ARADDR,
    output logic [7:0]              M_ARLEN,
    output logic [2:0]              M_ARSIZE,
    output logic [1:0]              M_ARBURST,
    output logic                    M_ARLOCK,
    output logic [3:0]              M_ARCACHE,
    output logic [2:0]              M_ARPROT,
    output logic [3:0]              M_ARREGION,
    output logic [3:0]              M_ARQOS,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    input  logic [C_ID_WIDTH:0]     M_RID,
    input  logic [C_DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RLAST,
    input  logic                    M_RVALID,
    output logic                    M_RREADY,
    output logic                    BUSY,
    output logic                    ERR
);
    arb_state_t              r_state;
    port_idx_t               r_rr;
    logic [C_ID_WIDTH:0]     r_id;
    logic [C_ADDR_WIDTH-1:0] r_addr;
    ar_payload_t             r_pl;
    logic [1:0]              w_full, w_busy, w_err, w_elig, w_inc, w_dec;
    logic                    w_gnt, w_rhs;
    port_idx_t               w_win, w_rp;

    assign w_elig = {S1_ARVALID & ~w_full[1], S0_ARVALID & ~w_full[0]};
    // Urgent scanout beats round-robin; otherwise the port not served last wins a tie.
    assign w_win  = (S1_URGENT & w_elig[1]) ? 1'b1 : (&w_elig) ? ~r_rr : w_elig[1];
    assign w_gnt  = (r_state == IDLE) & (|w_elig) & ~RST;
    assign S0_ARREADY = w_gnt & ~w_win;
    assign S1_ARREADY = w_gnt & w_win;
    assign w_inc = {S1_ARREADY, S0_ARREADY};

    assign w_rp  = M_RID[C_ID_WIDTH];
    assign w_rhs = M_RVALID & M_RREADY & M_RLAST;
    assign w_dec = {w_rhs & w_rp, w_rhs & ~w_rp};

    for (genvar k = 0; k < 2; k++) begin : g_trk
        outstanding_tracker #(.C_MAX_OUTSTANDING(C_MAX_OUTSTANDING)) u_trk (
            .i_clk (CLK),
            .i_rst (RST),
            .i_inc (w_inc[k]),
            .i_dec (w_dec[k]),
            .o_full(w_full[k]),
            .o_busy(w_busy[k]),
            .o_err (w_err[k])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_rr    <= 1'b1;
            r_id    <= '0;
            r_addr  <= '0;
            r_pl    <= '0;
        end else if (w_gnt) begin
            r_state <= ISSUE;
            r_rr    <= w_win;
            r_id    <= w_win ? {1'b1, S1_ARID} : {1'b0, S0_ARID};
            r_addr  <= w_win ? S1_ARADDR : S0_ARADDR;
            r_pl    <= w_win ? {S1_ARLEN, S1_ARSIZE, S1_ARBURST} : {S0_ARLEN, S0_ARSIZE, S0_ARBURST};
        end else if (r_state == ISSUE && M_ARREADY) begin
            r_state <= IDLE;
        end
    end

    assign M_ARVALID  = r_state == ISSUE;
    assign M_ARID     = r_id;
    assign M_ARADDR   = r_addr;
    assign M_ARLEN    = r_pl.len;
    assign M_ARSIZE   = r_pl.size;
    assign M_ARBURST  = r_pl.burst;
    assign M_ARLOCK   = 1'b0;
    assign M_ARCACHE  = AR_CACHE_DEFAULT;
    assign M_ARPROT   = 3'b0;
    assign M_ARREGION = 4'b0;
    assign M_ARQOS    = {3'b0, r_id[C_ID_WIDTH]};

    assign S0_RVALID = M_RVALID & ~w_rp;
    assign S1_RVALID = M_RVALID & w_rp;
    assign S0_RID    = M_RID[C_ID_WIDTH-1:0];
    assign S1_RID    = M_RID[C_ID_WIDTH-1:0];
    assign S0_RDATA  = M_RDATA;
    assign S1_RDATA  = M_RDATA;
    assign S0_RRESP  = M_RRESP;
    assign S1_RRESP  = M_RRESP;
    assign S0_RLAST  = M_RLAST;
    assign S1_RLAST  = M_RLAST;
    assign M_RREADY  = w_rp ? S1_RREADY : S0_RREADY;

    assign BUSY = M_ARVALID | (|w_busy);
    assign ERR  = |w_err;
endmodule

// File: tb/tb_axi4_read_arbiter.sv
// tb_axi4_read_arbiter: directed sequences, an R-routing vector table and a randomized run against a behavioural model.
module tb_axi4_read_arbiter;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]   arvalid, arready, rready, rvalid, s_rlast;
    logic [1:0]   arid [2];
    logic [31:0]  araddr [2];
    logic [7:0]   arlen [2];
    logic [2:0]   arsize [2];
    logic [1:0]   arburst [2];
    logic [1:0]   s_rid [2];
    logic [511:0] s_rdata [2];
    logic [1:0]   s_rresp [2];
    logic         urgent, m_arready, m_rlast, m_rvalid, m_rready, m_arvalid, m_arlock, busy, err;
    logic [2:0]   m_arid, m_rid, m_arsize, m_arprot;
    logic [31:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [1:0]   m_arburst, m_rresp;
    logic [3:0]   m_arcache, m_arregion, m_arqos;
    logic [511:0] m_rdata;

    int n_checks = 0;
    int n_err = 0;

    axi4_read_arbiter dut (
        .CLK(clk), .RST(rst),
        .S0_ARID(arid[0]), .S0_ARADDR(araddr[0]), .S0_ARLEN(arlen[0]), .S0_ARSIZE(arsize[0]),
        .S0_ARBURST(arburst[0]), .S0_ARVALID(arvalid[0]), .S0_ARREADY(arready[0]),
        .S0_RID(s_rid[0]), .S0_RDATA(s_rdata[0]), .S0_RRESP(s_rresp[0]), .S0_RLAST(s_rlast[0]),
        .S0_RVALID(rvalid[0]), .S0_RREADY(rready[0]),
        .S1_ARID(arid[1]), .S1_ARADDR(araddr[1]), .S1_ARLEN(arlen[1]), .S1_ARSIZE(arsize[1]),
        .S1_ARBURST(arburst[1]), .S1_ARVALID(arvalid[1]), .S1_ARREADY(arready[1]),
        .S1_RID(s_rid[1]), .S1_RDATA(s_rdata[1]), .S1_RRESP(s_rresp[1]), .S1_RLAST(s_rlast[1]),
        .S1_RVALID(rvalid[1]), .S1_RREADY(rready[1]),
        .S1_URGENT(urgent),
        .M_ARID(m_arid), .M_ARADDR(m_araddr), .M_ARLEN(m_arlen), .M_ARSIZE(m_arsize),
        .M_ARBURST(m_arburst), .M_ARLOCK(m_arlock), .M_ARCACHE(m_arcache), .M_ARPROT(m_arprot),
        .M_ARREGION(m_arregion), .M_ARQOS(m_arqos), .M_ARVALID(m_arvalid), .M_ARREADY(m_arready),
        .M_RID(m_rid), .M_RDATA(m_rdata), .M_RRESP(m_rresp), .M_RLAST(m_rlast),
        .M_RVALID(m_rvalid), .M_RREADY(m_rready),
        .BUSY(busy), .ERR(err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        arvalid = 2'b00; rready = 2'b11; urgent = 1'b0; m_arready = 1'b1;
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rid = 3'b0; m_rdata = '0; m_rresp = 2'b0;
        for (int k = 0; k < 2; k++) begin
            arid[k] = 2'b0; araddr[k] = 32'b0; arlen[k] = 8'b0; arsize[k] = 3'd6; arburst[k] = 2'b01;
        end
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (arready != 2'b00) begin
                g = int'(arready[1]);
                tick();
                return;
            end
            tick();
        end
    endtask

    typedef struct {
        logic [2:0] rid;
        logic       rv;
        logic [1:0] rr;
        logic [1:0] exp_rv;
        logic       exp_mrr;
        logic [1:0] exp_rid;
    } rvec_t;

    typedef struct {
        logic [2:0] id;
        int         len;
    } burst_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rvec_t  tbl [6];
        burst_t sq [$];
        int     g, cnt [2], rr, beat, w, p;
        bit     issue, merr, hs;
        logic [1:0]  exp_ar, elig;
        logic [2:0]  pid;
        logic [31:0] paddr;
        logic [7:0]  plen;

        tbl[0] = '{3'b000, 1'b1, 2'b11, 2'b01, 1'b1, 2'd0};
        tbl[1] = '{3'b101, 1'b1, 2'b11, 2'b10, 1'b1, 2'd1};
        tbl[2] = '{3'b110, 1'b1, 2'b01, 2'b10, 1'b0, 2'd2};
        tbl[3] = '{3'b011, 1'b1, 2'b10, 2'b01, 1'b0, 2'd3};
        tbl[4] = '{3'b111, 1'b0, 2'b10, 2'b00, 1'b1, 2'd3};
        tbl[5] = '{3'b010, 1'b0, 2'b00, 2'b00, 1'b0, 2'd2};

        // Reset state, with requests already asserted.
        drive_idle();
        arvalid = 2'b11;
        tick();
        chk("rst_arready", arready, 2'b00);
        chk("rst_m_arvalid", m_arvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_m_arid", m_arid, 3'b0);
        do_reset();

        // R routing table.
        for (int i = 0; i < 6; i++) begin
            m_rid = tbl[i].rid; m_rvalid = tbl[i].rv; rready = tbl[i].rr;
            m_rdata = {16{$urandom}};
            #1;
            p = int'(tbl[i].rid[2]);
            chk($sformatf("tbl%0d_rvalid", i), rvalid, tbl[i].exp_rv);
            chk($sformatf("tbl%0d_mrready", i), m_rready, tbl[i].exp_mrr);
            chk($sformatf("tbl%0d_rid", i), s_rid[p], tbl[i].exp_rid);
            chk($sformatf("tbl%0d_rdata", i), (s_rdata[0] == m_rdata) && (s_rdata[1] == m_rdata), 1'b1);
        end
        do_reset();

        // Single port 0 burst, 4 beats.
        arvalid[0] = 1'b1; arid[0] = 2'd1; araddr[0] = 32'h1000; arlen[0] = 8'd3;
        #1 chk("single_arready", arready, 2'b01);
        tick();
        arvalid[0] = 1'b0;
        #1;
        chk("single_m_arvalid", m_arvalid, 1'b1);
        chk("single_m_arid", m_arid, 3'b001);
        chk("single_m_araddr", m_araddr, 32'h1000);
        chk("single_m_arlen", m_arlen, 8'd3);
        chk("single_m_arsize", m_arsize, 3'd6);
        chk("single_m_arburst", m_arburst, 2'b01);
        chk("single_m_arcache", m_arcache, 4'b0011);
        chk("single_m_arqos", m_arqos, 4'd0);
        chk("single_busy", busy, 1'b1);
        tick();
        chk("single_m_arvalid_done", m_arvalid, 1'b0);
        for (int b = 0; b < 4; b++) begin
            m_rvalid = 1'b1; m_rid = 3'b001; m_rlast = (b == 3);
            #1;
            chk("single_r_rvalid", rvalid, 2'b01);
            chk("single_r_rid", s_rid[0], 2'd1);
            chk("single_r_mrready", m_rready, 1'b1);
            chk("single_r_busy", busy, 1'b1);
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1 chk("single_busy_end", busy, 1'b0);
        do_reset();

        // Round-robin alternation, port 0 first.
        arvalid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_grant(g);
            chk($sformatf("rr_grant%0d", i), g, i % 2);
        end
        do_reset();

        // Urgent port 1 until its limit, then port 0, then port 1 after its first RLAST.
        arvalid = 2'b11; urgent = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g);
            chk($sformatf("urg_grant%0d", i), g, (i < 4) ? 1 : 0);
        end
        arvalid[0] = 1'b0;
        tick();
        chk("urg_blocked", arready, 2'b00);
        m_rvalid = 1'b1; m_rid = 3'b100; m_rlast = 1'b1;
        #1 chk("urg_r_rvalid", rvalid, 2'b10);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1 chk("urg_resume", arready, 2'b10);
        do_reset();

        // Master AR stall for 10 cycles, max ARLEN.
        m_arready = 1'b0;
        arvalid[0] = 1'b1; arid[0] = 2'd2; araddr[0] = 32'h2000; arlen[0] = 8'd255;
        #1 chk("stall_arready", arready, 2'b01);
        tick();
        arvalid = 2'b11; arid[1] = 2'd1; araddr[1] = 32'h3000; arid[0] = 2'd3; araddr[0] = 32'h4000;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("stall_m_arvalid", m_arvalid, 1'b1);
            chk("stall_m_araddr", m_araddr, 32'h2000);
            chk("stall_m_arid", m_arid, 3'b010);
            chk("stall_m_arlen", m_arlen, 8'd255);
            chk("stall_arready", arready, 2'b00);
            tick();
        end
        m_arready = 1'b1; arvalid = 2'b00;
        tick();
        chk("stall_release", m_arvalid, 1'b0);
        chk("stall_busy", busy, 1'b1);
        do_reset();

        // R back-pressure, then same-cycle accept and retire on port 0.
        arvalid[0] = 1'b1;
        tick();
        arvalid[0] = 1'b0;
        tick();
        m_rvalid = 1'b1; m_rid = 3'b100; rready = 2'b01;
        #1;
        chk("bp_mrready", m_rready, 1'b0);
        chk("bp_rvalid", rvalid, 2'b10);
        arvalid[0] = 1'b1; m_rid = 3'b000; m_rlast = 1'b1;
        #1;
        chk("same_arready", arready, 2'b01);
        chk("same_mrready", m_rready, 1'b1);
        tick();
        arvalid[0] = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
        tick();
        chk("same_busy_mid", busy, 1'b1);
        m_rvalid = 1'b1; m_rid = 3'b000; m_rlast = 1'b1;
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        chk("same_busy_end", busy, 1'b0);
        chk("same_err", err, 1'b0);
        do_reset();

        // Underflow on port 1, then async reset mid-ISSUE.
        m_rvalid = 1'b1; m_rid = 3'b100; m_rlast = 1'b1;
        #1 chk("uf_err_before", err, 1'b0);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1 chk("uf_err_set", err, 1'b1);
        tick();
        tick();
        chk("uf_err_sticky", err, 1'b1);
        arvalid[1] = 1'b1; m_arready = 1'b0;
        tick();
        arvalid[1] = 1'b0;
        #1 chk("ar_issue", m_arvalid, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("arst_m_arvalid", m_arvalid, 1'b0);
        chk("arst_err", err, 1'b0);
        chk("arst_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        do_reset();

        // Randomized run against a behavioural model with an in-order R slave.
        cnt[0] = 0; cnt[1] = 0; rr = 1; issue = 0; merr = 0; beat = 0;
        pid = '0; paddr = '0; plen = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                arvalid[k] = 1'($urandom_range(0, 1));
                arid[k] = 2'($urandom);
                araddr[k] = $urandom;
                arlen[k] = 8'($urandom_range(0, 3));
                rready[k] = ($urandom_range(0, 3) != 0);
            end
            urgent = ($urandom_range(0, 3) == 0);
            m_arready = 1'($urandom_range(0, 1));
            m_rdata = {16{$urandom}};
            if (sq.size() > 0 && $urandom_range(0, 2) != 0) begin
                m_rvalid = 1'b1; m_rid = sq[0].id; m_rlast = (beat == sq[0].len);
            end else begin
                m_rvalid = 1'b0; m_rid = 3'($urandom); m_rlast = 1'($urandom);
            end
            #2;
            elig[0] = arvalid[0] && cnt[0] < MAXO;
            elig[1] = arvalid[1] && cnt[1] < MAXO;
            exp_ar = 2'b00; w = 0;
            if (!issue && elig != 2'b00) begin
                if (urgent && elig[1]) w = 1;
                else if (elig == 2'b11) w = 1 - rr;
                else w = elig[1] ? 1 : 0;
                exp_ar[w] = 1'b1;
            end
            chk("rnd_arready", arready, exp_ar);
            chk("rnd_m_arvalid", m_arvalid, issue);
            if (issue) begin
                chk("rnd_m_arid", m_arid, pid);
                chk("rnd_m_araddr", m_araddr, paddr);
                chk("rnd_m_arlen", m_arlen, plen);
                chk("rnd_m_arqos", m_arqos, {3'b0, pid[2]});
            end
            p = int'(m_rid[2]);
            chk("rnd_mrready", m_rready, rready[p]);
            chk("rnd_rvalid", rvalid, m_rvalid ? ((p == 1) ? 2'b10 : 2'b01) : 2'b00);
            chk("rnd_busy", busy, issue || cnt[0] != 0 || cnt[1] != 0);
            chk("rnd_err", err, merr);
            hs = m_rvalid && rready[p];
            if (hs) begin
                if (m_rlast) begin
                    if (cnt[p] == 0) merr = 1; else cnt[p]--;
                    void'(sq.pop_front());
                    beat = 0;
                end else beat++;
            end
            if (issue && m_arready) begin
                sq.push_back('{pid, int'(plen)});
                issue = 0;
            end else if (exp_ar != 2'b00) begin
                issue = 1; rr = w; cnt[w]++;
                pid = {w == 1, arid[w]}; paddr = araddr[w]; plen = arlen[w];
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
